// File: rtl/bt_uart_pkg.sv
// bt_uart shared definitions: FSM encoding and baud helpers.
// Common to bt_uart_tx and the future bt_uart_rx.
package bt_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DEF_CLK_HZ = 50_000_000;
  localparam int DEF_BAUD   = 9600;
  localparam int DATA_BITS  = 8;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

  function automatic int baud_cnt_w(
    input int clk_hz,
    input int baud
  );
    return $clog2(clks_per_bit(clk_hz, baud));
  endfunction

endpackage

// File: rtl/bt_sync_fifo.sv
// bt_sync_fifo: small synchronous FIFO, show-ahead read port.
// Writes are gated by full as seen at the start of the cycle.
module bt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bt_uart_tx.sv
// bt_uart_tx: buffers strobed bytes and sends them as 8N1 frames.
// tx is registered; back-to-back frames are gapless.
module bt_uart_tx
  import bt_uart_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int BAUD       = DEF_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW   = baud_cnt_w(CLK_HZ, BAUD);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            pop;
  logic            baud_tick;
  logic [7:0]      fifo_dout;
  logic            full;
  logic            empty;
  logic [CNTW-1:0] fifo_count;

  bt_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign in_ready  = ~full;
  assign overflow  = in_valid & full;
  assign busy      = (state_q != IDLE) | (fifo_count != '0);
  assign tx        = tx_q;
  assign baud_tick = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          // chain straight into the next start bit when more data waits
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_bt_uart_tx.sv
// tb_bt_uart_tx: randomized and directed checks of bt_uart_tx
// against a frame-timeline reference model and a line decoder.
module tb_bt_uart_tx;

  localparam int DEPTH = 4;
  localparam int FRAME = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, tx, busy, overflow;

  always #5 clk = ~clk;

  bt_uart_tx #(
    .CLK_HZ     (80),
    .BAUD       (10),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  int passed = 0;
  int total  = 0;

  // reference model: queued bytes plus the timeline of the frame on the line
  logic [7:0] m_q[$];
  logic [7:0] m_rx[$];
  logic [7:0] cur = 8'h00;
  int me = 0;
  int cur_start = -1000;
  int free_at = 0;
  logic e_tx, e_busy, e_rdy, e_ovf;

  function automatic logic model_tx();
    int j;
    int b;
    if (me >= free_at) return 1'b1;
    j = me - cur_start;
    b = j / 8;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return cur[b-1];
  endfunction

  task automatic apply(input logic v, input logic [7:0] d, input logic r);
    in_valid = v;
    in_data  = d;
    rst      = r;
    @(negedge clk);
    e_tx   = model_tx();
    e_busy = (me < free_at) || (m_q.size() > 0);
    e_rdy  = (m_q.size() < DEPTH);
    e_ovf  = v && (m_q.size() == DEPTH);
  endtask

  task automatic advance();
    int sz;
    @(posedge clk);
    me++;
    if (rst) begin
      m_q.delete();
      if (me < free_at) begin
        void'(m_rx.pop_back());
        free_at = me;
      end
    end else begin
      sz = m_q.size();
      if (me >= free_at && sz > 0) begin
        cur = m_q.pop_front();
        m_rx.push_back(cur);
        cur_start = me;
        free_at = me + FRAME;
      end
      if (in_valid && sz < DEPTH) m_q.push_back(in_data);
    end
    #1;
  endtask

  // line decoder: samples mid-bit and collects whole frames
  logic [7:0] rx_q[$];
  logic       mon_on = 1'b0;
  int         k = 0;
  int         frame_err = 0;
  logic [7:0] mon_sh = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      mon_on = 1'b0;
    end else begin
      if (!mon_on && tx === 1'b0) begin
        mon_on = 1'b1;
        k = -1;
      end
      if (mon_on) begin
        k++;
        if (k % 8 == 4) begin
          if (k / 8 == 0 && tx !== 1'b0) frame_err++;
          else if (k / 8 == 9 && tx !== 1'b1) frame_err++;
          else if (k / 8 >= 1 && k / 8 <= 8) mon_sh = {tx, mon_sh[7:1]};
        end
        if (k == FRAME - 1) begin
          rx_q.push_back(mon_sh);
          mon_on = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    apply(1'b0, 8'h00, 1'b1);
    advance();
    apply(1'b1, 8'hEE, 1'b1);
    advance();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 8'($urandom), 1'b0);
      total++;
      if ({tx, busy, in_ready, overflow} !== 4'b1010)
        $display("FAIL reset_state i=%0d: got tx/busy/rdy/ovf=%b want 1010",
                 i, {tx, busy, in_ready, overflow});
      else passed++;
      advance();
    end
    m_rx.delete();
    rx_q.delete();
  endtask

  task automatic test_single();
    logic ok;
    apply(1'b1, 8'hA5, 1'b0);
    advance();
    for (int i = 0; i < 95; i++) begin
      apply(1'b0, 8'($urandom), 1'b0);
      total++;
      if ({tx, busy, in_ready, overflow} !== {e_tx, e_busy, e_rdy, e_ovf})
        $display("FAIL single_cyc i=%0d: got %b want %b", i,
                 {tx, busy, in_ready, overflow}, {e_tx, e_busy, e_rdy, e_ovf});
      else passed++;
      if (i == 1 || i == 81) begin
        total++;
        if (tx !== (i == 81) || busy !== (i == 1))
          $display("FAIL single_edge i=%0d: got tx=%b busy=%b", i, tx, busy);
        else passed++;
      end
      advance();
    end
    ok = (rx_q.size() == 1) && (rx_q[0] === 8'hA5);
    total++;
    if (!ok) $display("FAIL single_byte: got %0d bytes want 1 byte a5", rx_q.size());
    else passed++;
    m_rx.delete();
    rx_q.delete();
  endtask

  task automatic test_back_to_back();
    logic ok;
    apply(1'b1, 8'h00, 1'b0);
    advance();
    apply(1'b1, 8'hFF, 1'b0);
    advance();
    for (int i = 0; i < 175; i++) begin
      apply(1'b0, 8'($urandom), 1'b0);
      total++;
      if ({tx, busy, in_ready, overflow} !== {e_tx, e_busy, e_rdy, e_ovf})
        $display("FAIL b2b_cyc i=%0d: got %b want %b", i,
                 {tx, busy, in_ready, overflow}, {e_tx, e_busy, e_rdy, e_ovf});
      else passed++;
      advance();
    end
    ok = (rx_q.size() == 2) && (rx_q[0] === 8'h00) && (rx_q[1] === 8'hFF);
    total++;
    if (!ok) $display("FAIL b2b_order: got %0d bytes want 00 ff", rx_q.size());
    else passed++;
    m_rx.delete();
    rx_q.delete();
  endtask

  task automatic test_overflow();
    int ovf_n = 0;
    int low_n = 0;
    logic ok;
    for (int i = 0; i < 500; i++) begin
      if (i < 6) apply(1'b1, 8'(i + 1), 1'b0);
      else apply(1'b0, 8'($urandom), 1'b0);
      if (overflow === 1'b1) ovf_n++;
      if (in_ready === 1'b0) low_n++;
      total++;
      if ({tx, busy, in_ready, overflow} !== {e_tx, e_busy, e_rdy, e_ovf})
        $display("FAIL ovf_cyc i=%0d: got %b want %b", i,
                 {tx, busy, in_ready, overflow}, {e_tx, e_busy, e_rdy, e_ovf});
      else passed++;
      advance();
    end
    total++;
    if (ovf_n != 1) $display("FAIL ovf_pulses: got %0d want 1", ovf_n);
    else passed++;
    total++;
    if (low_n != 77) $display("FAIL ovf_ready_low: got %0d want 77", low_n);
    else passed++;
    ok = (rx_q.size() == 5);
    for (int i = 0; i < 5 && ok; i++) if (rx_q[i] !== 8'(i + 1)) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL ovf_order: got %0d bytes want 01..05", rx_q.size());
    else passed++;
    m_rx.delete();
    rx_q.delete();
  endtask

  task automatic test_reset_mid();
    apply(1'b1, 8'h3C, 1'b0);
    advance();
    for (int i = 0; i < 120; i++) begin
      apply(1'b0, 8'($urandom), i == 36);
      total++;
      if ({tx, busy, in_ready, overflow} !== {e_tx, e_busy, e_rdy, e_ovf})
        $display("FAIL rstmid_cyc i=%0d: got %b want %b", i,
                 {tx, busy, in_ready, overflow}, {e_tx, e_busy, e_rdy, e_ovf});
      else passed++;
      if (i == 37) begin
        total++;
        if (tx !== 1'b1 || busy !== 1'b0)
          $display("FAIL rstmid_abort: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
        else passed++;
      end
      advance();
    end
    total++;
    if (rx_q.size() != 0 || m_rx.size() != 0)
      $display("FAIL rstmid_noframe: got %0d bytes want 0", rx_q.size());
    else passed++;
    apply(1'b1, 8'h55, 1'b0);
    advance();
    for (int i = 0; i < 90; i++) begin
      apply(1'b0, 8'($urandom), 1'b0);
      total++;
      if ({tx, busy, in_ready, overflow} !== {e_tx, e_busy, e_rdy, e_ovf})
        $display("FAIL rstmid_new i=%0d: got %b want %b", i,
                 {tx, busy, in_ready, overflow}, {e_tx, e_busy, e_rdy, e_ovf});
      else passed++;
      advance();
    end
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55)
      $display("FAIL rstmid_clean: got %0d bytes want 1 byte 55", rx_q.size());
    else passed++;
    m_rx.delete();
    rx_q.delete();
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] sent[$];
    logic [7:0] d;
    logic v;
    logic ok;
    for (int i = 0; i < 420; i++) begin
      v = (i < 3) || (i == 81) || (i == 161);
      d = 8'($urandom);
      if (v) sent.push_back(d);
      apply(v, d, 1'b0);
      total++;
      if ({tx, busy, in_ready, overflow} !== {e_tx, e_busy, e_rdy, e_ovf})
        $display("FAIL simul_cyc i=%0d: got %b want %b", i,
                 {tx, busy, in_ready, overflow}, {e_tx, e_busy, e_rdy, e_ovf});
      else passed++;
      if (i == 81 || i == 82 || i == 162) begin
        total++;
        if (dut.u_fifo.count !== 3'd2)
          $display("FAIL simul_count i=%0d: got %0d want 2", i, dut.u_fifo.count);
        else passed++;
      end
      advance();
    end
    ok = (rx_q.size() == sent.size());
    foreach (sent[i]) if (i < rx_q.size() && rx_q[i] !== sent[i]) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL simul_order: got %0d bytes want %0d", rx_q.size(), sent.size());
    else passed++;
    m_rx.delete();
    rx_q.delete();
  endtask

  task automatic test_random();
    logic ok;
    for (int i = 0; i < 1400; i++) begin
      apply((i < 900) && ($urandom_range(0, 9) == 0), 8'($urandom), 1'b0);
      total++;
      if ({tx, busy, in_ready, overflow} !== {e_tx, e_busy, e_rdy, e_ovf})
        $display("FAIL rand_cyc i=%0d: got %b want %b", i,
                 {tx, busy, in_ready, overflow}, {e_tx, e_busy, e_rdy, e_ovf});
      else passed++;
      advance();
    end
    ok = (rx_q.size() == m_rx.size()) && (m_rx.size() > 0);
    foreach (m_rx[i]) if (i < rx_q.size() && rx_q[i] !== m_rx[i]) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL rand_order: got %0d bytes want %0d", rx_q.size(), m_rx.size());
    else passed++;
    total++;
    if (frame_err != 0) $display("FAIL framing: got %0d errors want 0", frame_err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_simul_push_pop();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bt_uart_tx.md
Name: bt_uart_tx

Overview:
- Downstream consumer of the Bluetooth byte-source stage, which emits an 8-bit byte with a 1-bit strobe.
- Buffers strobed bytes in a small synchronous FIFO.
- Serialises them as 8N1 UART frames onto the TX line driving the Bluetooth module's RXD pin.
- Reports busy and overflow status back to the byte source.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer division), which must be at least 2.
- FIFO_DEPTH, 4, number of byte entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte strobe, one cycle per byte.
- in_data  in  8  byte to transmit, sampled when in_valid=1.
- in_ready  out  1  1 when FIFO not full; byte accepted this cycle if in_valid=1.
- tx  out  1  serial line, idle high.
- busy  out  1  1 while a frame is in flight or FIFO non-empty.
- overflow  out  1  one-cycle pulse when in_valid=1 and FIFO full (byte dropped).

Behaviour:
- Interface is fixed: one clock (clk); reset rst is synchronous and active-high.
- Reset values (and outputs on the cycle after any rst=1 edge):
  - tx=1, busy=0, overflow=0, in_ready=1.
  - FIFO emptied; FSM returns to IDLE; bit and baud counters cleared.
- Reset mid-frame aborts the frame immediately: tx=1 on the next edge, no stop bit completion.
- FIFO write:
  - Occurs on in_valid & ~full, with full evaluated at the start of the cycle.
  - A pop in the same cycle does not free space for that write; there is no pass-through.
  - Simultaneous push and pop when 0<count<DEPTH leaves count unchanged and preserves order.
- Overflow: in_valid & full gives overflow=1 for exactly that cycle. The byte is discarded and FIFO contents are unchanged.
- Pointers wrap modulo FIFO_DEPTH. count has width clog2(DEPTH)+1. full = (count==DEPTH), empty = (count==0).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop head into shift register, clear baud counter, go to START. tx stays 1 during IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit_idx=7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At expiry, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency:
  - Byte strobed into an empty FIFO with FSM in IDLE at edge N: FIFO non-empty at N+1, pop and START entered at N+2.
  - tx falls at edge N+2.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- tx is registered, never combinational from FIFO contents.
- busy = (state != IDLE) | ~empty, registered or derived from registered state only.
- in_data is ignored when in_valid=0.

Decomposition:
- Shared package/header bt_uart_pkg:
  - FSM state encoding constants (IDLE=0, START=1, DATA=2, STOP=3).
  - Function computing CLKS_PER_BIT and counter width clog2(CLKS_PER_BIT).
  - Common baud parameters, so the future bt_uart_rx uses identical definitions.
- One sub-module: bt_sync_fifo.
  - Parameters: WIDTH=8, DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Same clk and rst semantics.
  - Instantiated once inside bt_uart_tx.

Test Plan:
- All scenarios use CLK_HZ=80, BAUD=10, giving CLKS_PER_BIT=8.
- Single byte: reset, then one strobe with in_data=8'hA5 -> tx low for 8 cycles starting 2 edges later, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, high stop bit; busy falls after 80 cycles; overflow never asserts.
- Back-to-back: strobe 8'h00 then 8'h FF on consecutive cycles -> two contiguous 80-cycle frames with no idle cycle between the stop bit and the second start bit; order is 00 then FF.
- Overflow: with FIFO_DEPTH=4, strobe 8'h01..8'h06 on 6 consecutive cycles -> first byte popped at cycle 2; bytes 01–05 transmitted in order; overflow pulses once on the 6th strobe (06 dropped) only if the FIFO was full at that cycle; in_ready=0 exactly while count==4.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 of 8'h3C -> tx=1 on the next edge; busy=0; no further frame; a new strobe of 8'h55 afterwards produces a clean frame.
- Simultaneous push/pop: keep count at 2, strobe a new byte on the exact STOP-expiry pop cycle -> count stays 2; all bytes emerge in order with no duplication or loss.
